pe_dot_ctrl: RTL and testbench

Sequencing controller for the 32-lane int16 `pe_mult` datapath.
- Fetches `vec_num` 512-bit neuron/weight beats from two synchronous buffers.
- Drives the multiplier operands and reduces each 1024-bit product vector to one scalar.
- Accumulates the scalars across beats and reports one dot-product result per `start`.
- Sits between the PE instruction decoder and the `pe_mult` instance.

---
 rtl/pe_dot_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_pe_dot_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_dot_ctrl.sv
// pe_dot_ctrl: sequencing controller for the 32-lane int16 pe_mult datapath.
// Fetches vec_num neuron/weight beats, feeds pe_mult, reduces each product
// vector with an adder tree and accumulates one dot product per job.
// Optional build macro: PE_RELU_EN (fused ReLU on the reported result).
// Buffer data is captured into the operand registers at the clock edge that
// closes the strobe cycle, so beat k operands appear two cycles after accept+k.
module pe_dot_ctrl #(
  parameter int ADDR_W = 8,
  parameter int ACC_W  = 48
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    vec_num,
  output logic                 busy,
  output logic                 done,
  output logic [ACC_W-1:0]     result,
  output logic                 nrn_rd_en,
  output logic                 wgt_rd_en,
  output logic [ADDR_W-1:0]    nrn_rd_addr,
  output logic [ADDR_W-1:0]    wgt_rd_addr,
  input  logic [511:0]         nrn_rdata,
  input  logic [511:0]         wgt_rdata,
  output logic [511:0]         mult_neuron,
  output logic [511:0]         mult_weight,
  input  logic [1023:0]        mult_result
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t                   state;
  state_t                   state_nxt;
  logic [ADDR_W-1:0]        beat_n;
  logic [ADDR_W-1:0]        rd_addr_q;
  logic [1:0]               drain_cnt;
  logic                     v0;
  logic                     v1;
  logic                     v2;
  logic                     accept;
  logic                     last_beat;
  logic                     drain_last;
  logic [511:0]             neuron_q;
  logic [511:0]             weight_q;
  logic signed [36:0]       psum;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  psum_ext;
  logic [ACC_W-1:0]         result_q;
  logic [ACC_W-1:0]         result_nxt;

  logic signed [36:0]       lvl0 [32];
  logic signed [36:0]       lvl1 [16];
  logic signed [36:0]       lvl2 [8];
  logic signed [36:0]       lvl3 [4];
  logic signed [36:0]       lvl4 [2];
  logic signed [36:0]       tree_sum;

  assign accept     = (state == S_IDLE) && start;
  assign last_beat  = (rd_addr_q == (beat_n - ADDR_ONE));
  assign drain_last = (drain_cnt == 2'd2);
  assign psum_ext   = {{(ACC_W-37){psum[36]}}, psum};

  // State register; reset aborts any job in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus the state-derived handshake and read strobes.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    v0        = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (vec_num == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        busy = 1'b1;
        v0   = 1'b1;
        if (last_beat) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (drain_last) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Beat count latch, read address sequencer and drain counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_n    <= '0;
      rd_addr_q <= '0;
      drain_cnt <= 2'd0;
    end else begin
      if (accept) begin
        beat_n    <= vec_num;
        rd_addr_q <= '0;
      end else if (state == S_ISSUE) begin
        rd_addr_q <= last_beat ? '0 : (rd_addr_q + ADDR_ONE);
      end
      drain_cnt <= (state == S_DRAIN) ? (drain_cnt + 2'd1) : 2'd0;
    end
  end

  // Operand stage: capture buffer data on valid beats, zeros otherwise so pe_mult stays quiet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1       <= 1'b0;
      neuron_q <= '0;
      weight_q <= '0;
    end else begin
      v1       <= v0;
      neuron_q <= v0 ? nrn_rdata : '0;
      weight_q <= v0 ? wgt_rdata : '0;
    end
  end

  // Sign-extend the 32 products to 37 bits and reduce them with a balanced adder tree.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      lvl0[i] = {{5{mult_result[32*i+31]}}, mult_result[32*i +: 32]};
    end
    for (int i = 0; i < 16; i++) begin
      lvl1[i] = lvl0[2*i] + lvl0[2*i+1];
    end
    for (int i = 0; i < 8; i++) begin
      lvl2[i] = lvl1[2*i] + lvl1[2*i+1];
    end
    for (int i = 0; i < 4; i++) begin
      lvl3[i] = lvl2[2*i] + lvl2[2*i+1];
    end
    for (int i = 0; i < 2; i++) begin
      lvl4[i] = lvl3[2*i] + lvl3[2*i+1];
    end
    tree_sum = lvl4[0] + lvl4[1];
  end

  // Reduction and accumulate stages; a new job clears the accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2   <= 1'b0;
      psum <= '0;
      acc  <= '0;
    end else begin
      v2   <= v1;
      psum <= v1 ? tree_sum : '0;
      if (accept) begin
        acc <= '0;
      end else if (v2) begin
        acc <= acc + psum_ext;
      end
    end
  end

  // Value reported at the done cycle, optionally clamped at zero.
  always_comb begin
`ifdef PE_RELU_EN
    result_nxt = acc[ACC_W-1] ? '0 : acc;
`else
    result_nxt = acc;
`endif
  end

  // Result register: loaded only on entry to DONE, held at all other times.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
    end else if ((state == S_DRAIN) && drain_last) begin
      result_q <= result_nxt;
    end else if (accept && (vec_num == '0)) begin
      result_q <= '0;
    end
  end

  assign result      = result_q;
  assign nrn_rd_en   = v0;
  assign wgt_rd_en   = v0;
  assign nrn_rd_addr = rd_addr_q;
  assign wgt_rd_addr = rd_addr_q;
  assign mult_neuron = neuron_q;
  assign mult_weight = weight_q;

endmodule

// File: tb/tb_pe_dot_ctrl.sv
// tb_pe_dot_ctrl: directed vector bench for pe_dot_ctrl with a behavioural
// buffer pair and a behavioural 32-lane pe_mult.
module tb_pe_dot_ctrl;

  localparam int ADDR_W = 8;
  localparam int ACC_W  = 48;

  typedef struct {
    int     n;
    int     mode;
    int     nv;
    int     wv;
    longint exp_raw;
  } vec_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [ADDR_W-1:0]   vec_num;
  logic                busy;
  logic                done;
  logic [ACC_W-1:0]    result;
  logic                nrn_rd_en;
  logic                wgt_rd_en;
  logic [ADDR_W-1:0]   nrn_rd_addr;
  logic [ADDR_W-1:0]   wgt_rd_addr;
  logic [511:0]        nrn_rdata;
  logic [511:0]        wgt_rdata;
  logic [511:0]        mult_neuron;
  logic [511:0]        mult_weight;
  logic [1023:0]       mult_result;

  logic [511:0]        nrn_mem [256];
  logic [511:0]        wgt_mem [256];

  int     total = 0;
  int     bad   = 0;
  int     job_reads;
  int     job_done_cyc;
  int     job_done_cnt;
  int     job_errs;
  longint job_result;
  longint done_time;

  vec_t   vecs [9];

  pe_dot_ctrl #(.ADDR_W(ADDR_W), .ACC_W(ACC_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .vec_num     (vec_num),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .nrn_rd_en   (nrn_rd_en),
    .wgt_rd_en   (wgt_rd_en),
    .nrn_rd_addr (nrn_rd_addr),
    .wgt_rd_addr (wgt_rd_addr),
    .nrn_rdata   (nrn_rdata),
    .wgt_rdata   (wgt_rdata),
    .mult_neuron (mult_neuron),
    .mult_weight (mult_weight),
    .mult_result (mult_result)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Buffers answer the strobe; junk on the bus when not strobed.
  assign nrn_rdata = nrn_rd_en ? nrn_mem[nrn_rd_addr] : {16{32'hDEADBEEF}};
  assign wgt_rdata = wgt_rd_en ? wgt_mem[wgt_rd_addr] : {16{32'hBEEFCAFE}};

  // Behavioural pe_mult: 32 signed 16x16 lane products.
  always_comb begin
    mult_result = '0;
    for (int i = 0; i < 32; i++) begin
      mult_result[32*i +: 32] = 32'($signed(mult_neuron[16*i +: 16]) * $signed(mult_weight[16*i +: 16]));
    end
  end

  function automatic longint expOf(input longint raw);
`ifdef PE_RELU_EN
    return (raw < 0) ? 64'sd0 : raw;
`else
    return raw;
`endif
  endfunction

  task automatic checkOutput(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // mode 0: constant lanes; mode 1: neuron lane = nv*(k+1); mode 2: neuron lane i = i-16.
  task automatic fillMem(input int n, input int mode, input int nv, input int wv);
    logic [15:0] nl;
    logic [15:0] wl;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 32; i++) begin
        if (mode == 0)      nl = 16'(nv);
        else if (mode == 1) nl = 16'(nv * (k + 1));
        else                nl = 16'(i - 16);
        wl = 16'(wv);
        nrn_mem[k][16*i +: 16] = nl;
        wgt_mem[k][16*i +: 16] = wl;
      end
    end
  endtask

  // Runs one job, checking the cycle-level protocol against the accept cycle.
  task automatic applyStimulus(input int n, input int restart_at, input int rst_at, input bit stop_at_done);
    int     dc;
    bit     rd_exp;
    logic [511:0] nexp;
    logic [511:0] wexp;
    longint prev_result;
    job_reads    = 0;
    job_done_cyc = -1;
    job_done_cnt = 0;
    job_errs     = 0;
    job_result   = 0;
    dc = (n == 0) ? 1 : n + 4;
    @(negedge clk);
    prev_result = longint'($signed(result));
    start   = 1'b1;
    vec_num = n[ADDR_W-1:0];
    @(posedge clk);
    for (int c = 1; c <= n + 8; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (restart_at != 0 && c >= restart_at && c < restart_at + 3) begin
        start   = 1'b1;
        vec_num = 8'd2;
      end
      rd_exp = (c >= 1) && (c <= n);
      if (nrn_rd_en !== rd_exp) job_errs++;
      if (rd_exp && (nrn_rd_addr !== ADDR_W'(c - 1))) job_errs++;
      if ((wgt_rd_en !== nrn_rd_en) || (wgt_rd_addr !== nrn_rd_addr)) job_errs++;
      if (busy !== (c <= dc)) job_errs++;
      if (done !== (c == dc)) job_errs++;
      if (c >= 2 && c <= n + 1) begin
        nexp = nrn_mem[c-2];
        wexp = wgt_mem[c-2];
      end else begin
        nexp = '0;
        wexp = '0;
      end
      if ((mult_neuron !== nexp) || (mult_weight !== wexp)) job_errs++;
      if (c < dc && longint'($signed(result)) != prev_result) job_errs++;
      if (nrn_rd_en) job_reads++;
      if (done) begin
        job_done_cnt++;
        job_done_cyc = c;
        job_result   = longint'($signed(result));
        done_time    = longint'($time);
        if (stop_at_done) return;
      end
      if (rst_at != 0 && c == rst_at) begin
        rst = 1'b1;
        #1;
        checkOutput("rst.busy",   longint'(busy), 0);
        checkOutput("rst.done",   longint'(done), 0);
        checkOutput("rst.rd_en",  longint'(nrn_rd_en | wgt_rd_en), 0);
        checkOutput("rst.rd_addr", longint'(nrn_rd_addr | wgt_rd_addr), 0);
        checkOutput("rst.mult",   longint'((|mult_neuron) | (|mult_weight)), 0);
        checkOutput("rst.result", longint'(result), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int w = 0; w < 12; w++) begin
          @(negedge clk);
          if (done) job_done_cnt++;
          if (busy || nrn_rd_en) job_errs++;
        end
        break;
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    vec_num = '0;
    @(negedge clk);
    checkOutput("reset.busy",   longint'(busy), 0);
    checkOutput("reset.done",   longint'(done), 0);
    checkOutput("reset.result", longint'(result), 0);
    checkOutput("reset.rd_en",  longint'(nrn_rd_en | wgt_rd_en), 0);
    checkOutput("reset.mult",   longint'((|mult_neuron) | (|mult_weight)), 0);
    @(negedge clk);
    rst = 1'b0;

    vecs[0] = '{1,   0, 1,      1,      64'sd32};
    vecs[1] = '{4,   1, 1,      -2,     -64'sd640};
    vecs[2] = '{2,   0, -32768, -32768, 64'sd68719476736};
    vecs[3] = '{0,   0, 0,      0,      64'sd0};
    vecs[4] = '{3,   1, 100,    -7,     -64'sd134400};
    vecs[5] = '{2,   2, 0,      3,      -64'sd96};
    vecs[6] = '{5,   1, 3,      5,      64'sd7200};
    vecs[7] = '{255, 0, 1,      1,      64'sd8160};
    vecs[8] = '{1,   0, 32767,  -32768, -64'sd34358689792};

    for (int v = 0; v < 9; v++) begin
      fillMem(vecs[v].n, vecs[v].mode, vecs[v].nv, vecs[v].wv);
      applyStimulus(vecs[v].n, 0, 0, 1'b0);
      checkOutput($sformatf("vec%0d.done_cyc", v), job_done_cyc, (vecs[v].n == 0) ? 1 : vecs[v].n + 4);
      checkOutput($sformatf("vec%0d.done_cnt", v), job_done_cnt, 1);
      checkOutput($sformatf("vec%0d.reads", v), job_reads, vecs[v].n);
      checkOutput($sformatf("vec%0d.protocol", v), job_errs, 0);
      checkOutput($sformatf("vec%0d.result", v), job_result, expOf(vecs[v].exp_raw));
    end

    // start re-asserted during ISSUE of an 8-beat job must be ignored.
    fillMem(8, 0, 2, 3);
    applyStimulus(8, 3, 0, 1'b0);
    checkOutput("ignore.reads",    job_reads, 8);
    checkOutput("ignore.done_cnt", job_done_cnt, 1);
    checkOutput("ignore.protocol", job_errs, 0);
    checkOutput("ignore.result",   job_result, expOf(64'sd1536));

    // Back-to-back jobs: second start in the cycle right after done.
    begin
      longint t1;
      fillMem(3, 0, 1, 1);
      applyStimulus(3, 0, 0, 1'b1);
      t1 = done_time;
      checkOutput("b2b.first.result", job_result, expOf(64'sd96));
      checkOutput("b2b.first.protocol", job_errs, 0);
      applyStimulus(2, 0, 0, 1'b1);
      checkOutput("b2b.second.result", job_result, expOf(64'sd64));
      checkOutput("b2b.second.protocol", job_errs, 0);
      checkOutput("b2b.period", (done_time - t1) / 10, 7);
    end

    // Reset in the third ISSUE cycle aborts the job without a done pulse.
    fillMem(8, 0, 1, 1);
    applyStimulus(8, 0, 3, 1'b0);
    checkOutput("abort.done_cnt", job_done_cnt, 0);
    checkOutput("abort.idle",     job_errs, 0);
    fillMem(1, 0, 1, 1);
    applyStimulus(1, 0, 0, 1'b0);
    checkOutput("after_rst.done_cyc", job_done_cyc, 5);
    checkOutput("after_rst.protocol", job_errs, 0);
    checkOutput("after_rst.result",   job_result, expOf(64'sd32));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
